uart_tx: RTL

//   UART transmitter, 8N1 by default. Companion to uart_rx: drives the ser_tx pin of the top level.

---
 rtl/uart_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, one-byte holding register, LSB-first serialisation
// with optional parity and one or two stop bits. All outputs are registered.
module uart_tx #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] data_tx,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [7:0] b);
        return (^b) ^ (PARITY_ODD != 0);
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic             parity_r, parity_s;
    logic [7:0]       hold_r, hold_s;
    logic             hold_full_r, hold_full_s;
    logic             tx_r, tx_s;
    logic             tx_ready_r;
    logic             busy_r;
    logic             tx_done_r, tx_done_s;
    logic             accept_s;
    logic             hold_write_s;
    logic             baud_end_s;

    // Next-state logic: handshake, holding register, bit timing and frame sequencing
    always_comb begin
        accept_s     = tx_valid && tx_ready_r;
        hold_write_s = accept_s && (state_r != IDLE);
        baud_end_s   = (baud_cnt_r == BAUD_LAST);
        state_s      = state_r;
        baud_cnt_s   = baud_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        parity_s     = parity_r;
        hold_s       = hold_write_s ? data_tx : hold_r;
        hold_full_s  = hold_full_r | hold_write_s;

        if (state_r == IDLE) begin
            baud_cnt_s = {CNT_W{1'b0}};
            bit_cnt_s  = 3'd0;
            if (hold_full_r) begin
                shift_s     = hold_r;
                parity_s    = parity_bit(hold_r);
                hold_full_s = 1'b0;
                state_s     = START;
            end else if (accept_s) begin
                // Idle accept bypasses the holding register entirely
                shift_s  = data_tx;
                parity_s = parity_bit(data_tx);
                state_s  = START;
            end else begin
                state_s = IDLE;
            end
        end else if (!baud_end_s) begin
            baud_cnt_s = baud_cnt_r + CNT_W'(1);
        end else begin
            baud_cnt_s = {CNT_W{1'b0}};
            case (state_r)
                START: begin
                    bit_cnt_s = 3'd0;
                    state_s   = DATA;
                end
                DATA: begin
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_s = 3'd0;
                        state_s   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
                PARITY: begin
                    bit_cnt_s = 3'd0;
                    state_s   = STOP;
                end
                STOP: begin
                    if (bit_cnt_r != STOP_LAST) begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end else if (hold_full_r) begin
                        // Back-to-back frame: the next start bit follows with no idle gap
                        bit_cnt_s   = 3'd0;
                        shift_s     = hold_r;
                        parity_s    = parity_bit(hold_r);
                        hold_full_s = 1'b0;
                        state_s     = START;
                    end else begin
                        bit_cnt_s = 3'd0;
                        state_s   = IDLE;
                    end
                end
                default: begin
                    bit_cnt_s = 3'd0;
                    state_s   = IDLE;
                end
            endcase
        end
    end

    // Line level and end-of-frame pulse derived from the upcoming state so they can be registered
    always_comb begin
        tx_s      = 1'b1;
        tx_done_s = (state_s == STOP) && (baud_cnt_s == BAUD_LAST) && (bit_cnt_s == STOP_LAST);
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            PARITY:  tx_s = parity_s;
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            baud_cnt_r  <= {CNT_W{1'b0}};
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            parity_r    <= 1'b0;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            tx_r        <= 1'b1;
            tx_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            baud_cnt_r  <= baud_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            parity_r    <= parity_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            tx_r        <= tx_s;
            tx_ready_r  <= !hold_full_s;
            busy_r      <= (state_s != IDLE);
            tx_done_r   <= tx_done_s;
        end
    end

    assign tx_ready = tx_ready_r;
    assign tx       = tx_r;
    assign busy     = busy_r;
    assign tx_done  = tx_done_r;
endmodule
